// File: rtl/serial_deserializer_if.sv
// Handshake and data bundle between the serial deserializer and its neighbours.
// slave: the deserializer itself; master: upstream bit source plus downstream consumer.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_valid;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overflow;

    modport slave (
        input  sin,
        input  sin_valid,
        input  start,
        input  dout_ready,
        output dout,
        output dout_valid,
        output busy,
        output overflow
    );

    modport master (
        output sin,
        output sin_valid,
        output start,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  overflow
    );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel stage: assembles WIDTH-bit words from a strobed bit stream,
// presents each word on a valid/ready handshake and flags protocol errors.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic                 clock,
    input  logic                 clear_n,
    serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             overflow_r;
    logic [WIDTH-1:0] shifted;

    // Shift register contents after accepting the current sin bit.
    always_comb begin
        shifted = sreg;
        if (LSB_FIRST != 0) begin
            shifted = {bus.sin, sreg[WIDTH-1:1]};
        end else begin
            shifted = {sreg[WIDTH-2:0], bus.sin};
        end
    end

    // Frame state machine, bit assembly, output word and sticky error flag.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state        <= IDLE;
            sreg         <= '0;
            cnt          <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sreg  <= '0;
                    end
                end
                SHIFT: begin
                    // A new start wins over a concurrent bit: the frame restarts empty.
                    if (bus.start) begin
                        cnt  <= '0;
                        sreg <= '0;
                    end else if (bus.sin_valid) begin
                        sreg <= shifted;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            dout_r       <= shifted;
                            dout_valid_r <= 1'b1;
                            cnt          <= '0;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dout_valid_r && bus.dout_ready) begin
                        dout_valid_r <= 1'b0;
                        if (bus.start) begin
                            state <= SHIFT;
                            cnt   <= '0;
                            sreg  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.start) begin
                        overflow_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers; busy decodes the registered state.
    always_comb begin
        bus.dout       = dout_r;
        bus.dout_valid = dout_valid_r;
        bus.overflow   = overflow_r;
        bus.busy       = (state != IDLE);
    end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-to-parallel stage that consumes the bit stream produced by the one-bit register stage and assembles WIDTH-bit words.
- Frames are opened by a start pulse and bits are accepted on a sample strobe.
- A completed word is presented on a valid/ready handshake to downstream logic.
- Protocol errors are reported on a sticky overflow flag.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
LSB_FIRST, 0, bit order. 0 = first received bit lands in dout[WIDTH-1]; 1 = first received bit lands in dout[0].

Ports:
clock  input  1  system clock; all state updates on rising edge.
clear_n  input  1  asynchronous, active-low reset.
sin  input  1  serial data bit from the upstream one-bit register.
sin_valid  input  1  sin holds a bit to accept this cycle.
start  input  1  single-cycle pulse that opens a new frame.
dout  output  WIDTH  assembled word; stable while dout_valid=1.
dout_valid  output  1  dout holds a completed word.
dout_ready  input  1  consumer accepts dout this cycle.
busy  output  1  high whenever state is not IDLE.
overflow  output  1  sticky error flag.

Behaviour:
- Reset: clear_n=0 acts immediately, independent of clock.
  - State forced to IDLE; shift register and bit counter cleared.
  - dout=0, dout_valid=0, busy=0, overflow=0.
  - Reset mid-frame or mid-HOLD discards all partial or pending data.
- Bit counter is $clog2(WIDTH) bits wide.
- State machine, states IDLE, SHIFT, HOLD:
  - IDLE:
    - start=1 -> SHIFT; counter=0; shift register=0.
    - sin_valid is ignored in IDLE, including the cycle in which start is sampled.
  - SHIFT, each edge with sin_valid=1 shifts in sin and increments the counter:
    - LSB_FIRST=0: shift left, sin enters bit 0.
    - LSB_FIRST=1: shift right, sin enters bit WIDTH-1.
    - Cycles with sin_valid=0 hold all state; gaps of any length are legal.
  - SHIFT, final bit: on the edge that accepts the bit with counter=WIDTH-1, dout loads the complete word, including that bit, and dout_valid=1. Next state is HOLD.
    - Latency: dout_valid is visible immediately after the edge that samples the last bit.
  - SHIFT, start=1: aborts the partial frame and restarts it (counter=0, shift register=0). The concurrent sin_valid bit is dropped. overflow is not set.
  - HOLD:
    - dout and dout_valid hold until dout_valid and dout_ready are both high on an edge.
    - On that edge dout_valid goes to 0 and the state moves to IDLE; dout keeps its last value.
    - Handshake edge with start=1: go directly to SHIFT with counter cleared (back-to-back frames, no idle cycle).
    - start=1 without dout_ready: overflow set to 1; start is discarded and the state stays HOLD.
    - sin_valid is ignored in HOLD.
- overflow clears only on clear_n=0.
- busy is decoded from the registered state; no combinational path from inputs to any output.
- dout_ready has no effect outside HOLD.

Test Plan:
- MSB-first frame: WIDTH=8, LSB_FIRST=0, clear_n pulse, start, then sin 1,0,1,1,0,0,1,0 on consecutive sin_valid cycles -> dout=8'hB2 and dout_valid=1 after the 8th bit edge; busy=1 from the edge after start until the handshake.
- LSB-first frame: LSB_FIRST=1, same stream -> dout=8'h4D.
- Sparse strobes and backpressure: same frame with sin_valid gaps of 0-3 cycles -> dout=8'hB2. Then hold dout_ready=0 for 5 cycles -> dout stable at 8'hB2, dout_valid=1. Assert start during the hold -> overflow=1, state stays HOLD. Raise dout_ready -> dout_valid=0 next edge, overflow stays 1.
- Reset mid-frame: after 3 bits, pulse clear_n low asynchronously between edges -> all outputs 0 at once. Then a clean frame of eight 1s -> dout=8'hFF, overflow=0.
- Back-to-back frames: frame 8'hFF; the cycle its handshake completes, assert start; then eight 0 bits -> second dout=8'h00 with no IDLE cycle between frames; busy stays 1 throughout.
- Abort and restart: start, 4 bits of 1, start again, then bits 0,0,0,0,1,1,1,1 -> dout=8'h0F, overflow=0.
